// File: rtl/cla_pkg.sv
`default_nettype none
//============================================================================
// Package     : cla_pkg
// Description : Shared constants and sizing helpers for the CLA adder family.
// Revision    : 1.0 - initial release
//============================================================================
package cla_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int ngroups(input int width, input int group);
        return width / group;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
//============================================================================
// Module      : cla_group
// Description : One look-ahead group: in-group carries plus group P/G.
// Revision    : 1.0 - initial release
//============================================================================
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] i_p,
    input  logic [GROUP-1:0] i_g,
    input  logic             i_cin,
    output logic [GROUP-1:0] o_carry,
    output logic             o_gp,
    output logic             o_gg
);

    logic w_term;

    // o_carry[i] is the carry into bit i, each one a flat sum of products
    always_comb begin
        w_term  = 1'b0;
        o_carry = '0;
        o_gg    = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            w_term = i_cin;
            for (int m = 0; m < i; m++) w_term = w_term & i_p[m];
            o_carry[i] = w_term;
            for (int j = 0; j < i; j++) begin
                w_term = i_g[j];
                for (int m = j + 1; m < i; m++) w_term = w_term & i_p[m];
                o_carry[i] = o_carry[i] | w_term;
            end
        end
        for (int j = 0; j < GROUP; j++) begin
            w_term = i_g[j];
            for (int m = j + 1; m < GROUP; m++) w_term = w_term & i_p[m];
            o_gg = o_gg | w_term;
        end
    end

    assign o_gp = &i_p;

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
//============================================================================
// Module      : pipelined_cla_adder
// Description : Two-stage pipelined two-level CLA adder/subtractor, valid/ready.
// Revision    : 1.0 - initial release
//============================================================================
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NGROUPS = ngroups(WIDTH, GROUP);

    if ((WIDTH % GROUP) != 0) begin : g_width_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
    end

    logic [WIDTH-1:0]   w_b_eff, w_p, w_g;
    logic               w_c0;
    logic [NGROUPS-1:0] w_gp, w_gg;
    logic [WIDTH-1:0]   w_s1_carry_unused;
    logic [NGROUPS-1:0] w_s2_gp_unused, w_s2_gg_unused;
    logic [NGROUPS:0]   w_gc;
    logic [WIDTH-1:0]   w_carry, w_sum;
    logic               w_cout, w_ovf, w_term;
    logic               w_adv1, w_adv2;

    logic               r_v1, r_v2;
    logic [WIDTH-1:0]   r_p, r_g;
    logic [NGROUPS-1:0] r_gp, r_gg;
    logic               r_c0;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout, r_ovf, r_zero;

    // Subtraction is A + ~B + 1; the caller's carry-in is dropped in that mode
    assign w_b_eff = (in_sub == OP_SUB) ? ~in_b : in_b;
    assign w_c0    = (in_sub == OP_SUB) ? 1'b1 : in_cin;
    assign w_p     = in_a ^ w_b_eff;
    assign w_g     = in_a & w_b_eff;

    // Stage-1 instances only provide group P/G; stage-2 instances only carries
    for (genvar k = 0; k < NGROUPS; k++) begin : g_s1_group
        cla_group #(.GROUP(GROUP)) u_grp (
            .i_p     (w_p[k*GROUP +: GROUP]),
            .i_g     (w_g[k*GROUP +: GROUP]),
            .i_cin   (1'b0),
            .o_carry (w_s1_carry_unused[k*GROUP +: GROUP]),
            .o_gp    (w_gp[k]),
            .o_gg    (w_gg[k])
        );
    end

    // Second-level look-ahead: every group carry-in is a direct sum of products
    always_comb begin
        w_term  = 1'b0;
        w_gc    = '0;
        w_gc[0] = r_c0;
        for (int k = 1; k <= NGROUPS; k++) begin
            w_term = r_c0;
            for (int m = 0; m < k; m++) w_term = w_term & r_gp[m];
            w_gc[k] = w_term;
            for (int j = 0; j < k; j++) begin
                w_term = r_gg[j];
                for (int m = j + 1; m < k; m++) w_term = w_term & r_gp[m];
                w_gc[k] = w_gc[k] | w_term;
            end
        end
    end

    for (genvar k = 0; k < NGROUPS; k++) begin : g_s2_group
        cla_group #(.GROUP(GROUP)) u_grp (
            .i_p     (r_p[k*GROUP +: GROUP]),
            .i_g     (r_g[k*GROUP +: GROUP]),
            .i_cin   (w_gc[k]),
            .o_carry (w_carry[k*GROUP +: GROUP]),
            .o_gp    (w_s2_gp_unused[k]),
            .o_gg    (w_s2_gg_unused[k])
        );
    end

    assign w_sum  = r_p ^ w_carry;
    assign w_cout = w_gc[NGROUPS];
    assign w_ovf  = w_carry[WIDTH-1] ^ w_cout;

    assign w_adv2   = !r_v2 || out_ready;
    assign w_adv1   = !r_v1 || w_adv2;
    assign in_ready = w_adv1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_p    <= '0;
            r_g    <= '0;
            r_gp   <= '0;
            r_gg   <= '0;
            r_c0   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_p  <= w_p;
                    r_g  <= w_g;
                    r_gp <= w_gp;
                    r_gg <= w_gg;
                    r_c0 <= w_c0;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_sum  <= w_sum;
                    r_cout <= w_cout;
                    r_ovf  <= w_ovf;
                    r_zero <= (w_sum == '0);
                end
            end
        end
    end

    assign out_valid = r_v2;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;
    assign out_zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
//============================================================================
// Module      : tb_pipelined_cla_adder
// Description : Self-checking bench with an arithmetic reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_pipelined_cla_adder;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, in_cin, in_sub;
    logic [W-1:0] in_a, in_b, out_sum;
    logic         out_valid, out_ready, out_cout, out_ovf, out_zero;

    int   checks   = 0;
    int   failures = 0;
    int   n_in     = 0;
    int   n_out    = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    // Integer arithmetic: unsigned result for sum/carry, signed range for overflow
    function automatic res_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
        res_t r;
        int   ua, ub, u, sa, sb, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            u      = ua - ub;
            s      = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            u      = ua + ub + int'(cin);
            s      = sa + sb + int'(cin);
            r.cout = (u >= 65536);
        end
        r.sum  = u[W-1:0];
        r.ovf  = (s > 32767) || (s < -32768);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    // Compare process: scoreboard on every transfer, hold check on every stall
    initial begin
        logic prev_stall;
        res_t prev_out, e;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'({out_sum, out_cout, out_ovf, out_zero}), 32'(prev_out));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result actual=%h required=no_beat", out_sum);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sum", 32'(out_sum), 32'(e.sum));
                        chk("flags", 32'({out_cout, out_ovf, out_zero}), 32'({e.cout, e.ovf, e.zero}));
                    end
                    n_out++;
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = {out_sum, out_cout, out_ovf, out_zero};
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_model(in_a, in_b, in_cin, in_sub));
                    n_in++;
                end
            end
        end
    end

    // Single beat into an empty pipe; literal expectations and exact latency
    task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic [W-1:0] es,
                            input logic ec, input logic eo, input logic ez);
        res_t m;
        m = ref_model(a, b, cin, sub);
        chk({nm, "_model"}, 32'(m), 32'({es, ec, eo, ez}));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        chk({nm, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_result"}, 32'({out_sum, out_cout, out_ovf, out_zero}), 32'({es, ec, eo, ez}));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] bp_a[4];
        logic [W-1:0] bp_b[4];
        int idx, fires, base_in, base_out, cyc;
        logic acc, fire;

        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] bp_a[4];
        logic [W-1:0] bp_b[4];
        int idx, fires, base_in, base_out, cyc;
        logic acc, fire;
        bp_a = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0F0F};
        bp_b = '{16'h1111, 16'h0002, 16'h0001, 16'hF0F1};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", 32'({out_sum, out_cout, out_ovf, out_zero}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        directed("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("add_chain",  16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        directed("sub_cin1",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

        // Backpressure: five stalled cycles, then release with beats still queued
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 5);
            in_valid  = (idx < 4);
            in_a      = bp_a[idx & 3];
            in_b      = bp_b[idx & 3];
            in_cin    = 1'b0;
            in_sub    = 1'b0;
            @(negedge clk);
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (c == 4) begin
                chk("bp_accepted", 32'(idx), 32'd2);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            end
            if (c >= 5 && c <= 8) chk("bp_drain_rate", 32'(fire), 32'd1);
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;

        // Reset with two beats held in the pipe
        out_ready = 1'b0;
        in_valid  = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_sub = 1'b0; in_cin = 1'b0;
        @(posedge clk); #1;
        in_a = 16'h8000; in_b = 16'h8000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_mid_inflight", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_outputs", 32'({out_sum, out_cout, out_ovf, out_zero}), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        fires = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) fires++;
        end
        chk("rst_no_stale", 32'(fires), 32'd0);
        @(posedge clk); #1;

        // Random traffic with random backpressure
        base_in  = n_in;
        base_out = n_out;
        cyc      = 0;
        while ((n_in - base_in) < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = pick();
            in_b      = pick();
            in_cin    = 1'($urandom_range(0, 1));
            in_sub    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rand_beats_in", 32'(n_in - base_in), 32'd10000);
        chk("rand_in_eq_out", 32'(n_out - base_out), 32'(n_in - base_in));
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
